frame_pad_stream: RTL and testbench

Parametrised boundary-padding stage placed between demosaic and the k×k convolution filters. It accepts a raster pixel stream of WIDTH×HEIGHT multi-channel pixels and emits a (WIDTH+2B)×(HEIGHT+2B) padded raster, where B=(KERNEL-1)/2. Pad values are selectable at run time: zero, constant, or horizontal edge replicate. Unlike the inline pad logic it replaces, it buffers input in a FIFO and applies back-pressure (oReady), so pad insertion never drops pixels.

---
 rtl/frame_pad_stream_if.sv | 30 +++
 rtl/frame_pad_stream.sv | 187 ++++++++++++++++++
 tb/tb_frame_pad_stream.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pad_stream_if.sv
// Pixel stream interface for frame_pad_stream: input pixels with back-pressure,
// run-time pad controls, and the padded output raster with frame markers.
interface frame_pad_stream_if #(
  parameter int unsigned CH = 3,
  parameter int unsigned DW = 8
);
  localparam int unsigned PXW = CH * DW;

  logic           iValid;
  logic [PXW-1:0] iData;
  logic           oReady;
  logic [1:0]     padMode;
  logic [PXW-1:0] padConst;
  logic           oValid;
  logic [PXW-1:0] oData;
  logic           oFirst;
  logic           oLast;
  logic           oDone;
  logic           oOverflow;

  modport master (
    output iValid, iData, padMode, padConst,
    input  oReady, oValid, oData, oFirst, oLast, oDone, oOverflow
  );

  modport slave (
    input  iValid, iData, padMode, padConst,
    output oReady, oValid, oData, oFirst, oLast, oDone, oOverflow
  );
endinterface

// File: rtl/frame_pad_stream.sv
// Boundary-padding stage: buffers a WIDTHxHEIGHT raster in a FIFO and emits it
// surrounded by a B-pixel border (zero, constant or horizontal edge replicate).
module frame_pad_stream #(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned KERNEL     = 7,
  parameter int unsigned CH         = 3,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic               clk,
  input logic               reset,
  frame_pad_stream_if.slave bus
);

  localparam int unsigned PXW = CH * DW;
  localparam int unsigned B   = (KERNEL - 1) / 2;
  localparam int unsigned PW  = WIDTH + 2 * B;
  localparam int unsigned PH  = HEIGHT + 2 * B;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned XW  = $clog2(PW);
  localparam int unsigned YW  = $clog2(PH);

  typedef enum logic [2:0] {
    S_IDLE, S_TOP, S_LEFT, S_DATA, S_RIGHT, S_BOTTOM
  } state_e;

  state_e state_q;

  // Input FIFO
  logic [PXW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           ready_q, ovf_q;
  logic           wr_c, rd_c, empty_c;
  logic [PXW-1:0] head_c;

  assign empty_c = (count_q == '0);
  assign head_c  = mem_q[rd_ptr_q];
  assign wr_c    = bus.iValid & ready_q;
  assign rd_c    = (state_q == S_DATA) & ~empty_c;
  assign count_d = count_q + CW'(wr_c) - CW'(rd_c);

  always_ff @(posedge clk) begin
    if (wr_c) mem_q[wr_ptr_q] <= bus.iData;
  end

  // Ready is derived from the post-update count so the FIFO can never overfill.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d <= CW'(FIFO_DEPTH - 2));
      if (bus.iValid && !ready_q) ovf_q <= 1'b1;
    end
  end

  // Frame-latched pad settings and region counters
  logic [1:0]     mode_q;
  logic [PXW-1:0] const_q, hold_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic           valid_q, first_q, last_q, done_q;
  logic [PXW-1:0] data_q;
  logic [PXW-1:0] edge_pad_c;
  logic           repl_c;

  assign edge_pad_c = (mode_q == 2'd1) ? const_q : '0;
  assign repl_c     = (mode_q == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      const_q <= '0;
      hold_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        // The first TOP pixel is issued directly from IDLE using the live pad inputs.
        S_IDLE: begin
          if (!empty_c) begin
            mode_q  <= bus.padMode;
            const_q <= bus.padConst;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            data_q  <= (bus.padMode == 2'd1) ? bus.padConst : '0;
            x_q     <= XW'(1);
            y_q     <= '0;
            state_q <= S_TOP;
          end
        end
        S_TOP: begin
          valid_q <= 1'b1;
          data_q  <= edge_pad_c;
          if (x_q == XW'(PW - 1)) begin
            x_q <= '0;
            y_q <= y_q + YW'(1);
            if (y_q == YW'(B - 1)) state_q <= S_LEFT;
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        S_LEFT: begin
          if (!repl_c || !empty_c) begin
            valid_q <= 1'b1;
            data_q  <= repl_c ? head_c : edge_pad_c;
            if (x_q == XW'(B - 1)) begin
              x_q     <= '0;
              state_q <= S_DATA;
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        S_DATA: begin
          if (!empty_c) begin
            valid_q <= 1'b1;
            data_q  <= head_c;
            hold_q  <= head_c;
            if (x_q == XW'(WIDTH - 1)) begin
              x_q     <= '0;
              state_q <= S_RIGHT;
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        S_RIGHT: begin
          valid_q <= 1'b1;
          data_q  <= repl_c ? hold_q : edge_pad_c;
          if (x_q == XW'(B - 1)) begin
            x_q     <= '0;
            y_q     <= y_q + YW'(1);
            state_q <= (y_q == YW'(B + HEIGHT - 1)) ? S_BOTTOM : S_LEFT;
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        S_BOTTOM: begin
          valid_q <= 1'b1;
          data_q  <= edge_pad_c;
          if (x_q == XW'(PW - 1)) begin
            x_q <= '0;
            if (y_q == YW'(PH - 1)) begin
              last_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              y_q <= y_q + YW'(1);
            end
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.oReady    = ready_q;
  assign bus.oOverflow = ovf_q;
  assign bus.oValid    = valid_q;
  assign bus.oData     = data_q;
  assign bus.oFirst    = first_q;
  assign bus.oLast     = last_q;
  assign bus.oDone     = done_q;

endmodule

// File: tb/tb_frame_pad_stream.sv
// Self-checking bench for frame_pad_stream: directed and random frames compared
// against a raster-level padding model built from row/column arithmetic.
module tb_frame_pad_stream;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int K    = 3;
  localparam int B    = (K - 1) / 2;
  localparam int PW   = W + 2 * B;
  localparam int PH   = H + 2 * B;
  localparam int NPIX = W * H;
  localparam int NOUT = PW * PH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_pad_stream_if #(.CH(3), .DW(8)) bus ();

  frame_pad_stream #(
    .WIDTH(W), .HEIGHT(H), .KERNEL(K), .CH(3), .DW(8), .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [23:0] in_px [NPIX];
  logic [23:0] exp_px[$];
  logic [23:0] got_px[$];
  logic [2:0]  exp_fl[$];
  logic [2:0]  got_fl[$];

  int ncyc = 0;
  int first_cyc = 0;
  int acc_cyc = 0;
  int done_seen = 0;
  int bad_done = 0;

  // Output collector, sampled on the falling edge
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (!reset) begin
      if (bus.oValid) begin
        got_px.push_back(bus.oData);
        got_fl.push_back({bus.oFirst, bus.oLast, bus.oDone});
        if (bus.oFirst) first_cyc <= ncyc + 1;
      end
      if (bus.oDone) done_seen <= done_seen + 1;
      if (!bus.oValid && (bus.oDone || bus.oFirst || bus.oLast)) bad_done <= bad_done + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected padded raster for the current in_px frame
  task automatic model_frame(input logic [1:0] mode, input logic [23:0] pc);
    logic [23:0] pad, v;
    int p;
    pad = (mode == 2'd1) ? pc : 24'h0;
    p = 0;
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        int dr, dc;
        dr = r - B;
        dc = c - B;
        if (dr < 0 || dr >= H)   v = pad;
        else if (dc < 0)         v = (mode == 2'd2) ? in_px[dr * W] : pad;
        else if (dc >= W)        v = (mode == 2'd2) ? in_px[dr * W + W - 1] : pad;
        else                     v = in_px[dr * W + dc];
        exp_px.push_back(v);
        exp_fl.push_back({p == 0, p == NOUT - 1, p == NOUT - 1});
        p++;
      end
    end
  endtask

  // gap_mode: 0 none, 1 idle cycle after every 2 accepted pixels, 2 random idles
  task automatic send_frame(input logic [1:0] mode, input logic [23:0] pc,
                            input int gap_mode, input bit twiddle, input int npix);
    int i, run, guard;
    bit acc, gap;
    bus.padMode  = mode;
    bus.padConst = pc;
    i = 0; run = 0; guard = 0;
    while (i < npix && guard < 1000) begin
      gap = (gap_mode == 1 && run == 2) || (gap_mode == 2 && $urandom_range(0, 2) == 0);
      if (gap || !bus.oReady) begin
        bus.iValid = 1'b0;
        if (gap) run = 0;
      end else begin
        bus.iValid = 1'b1;
        bus.iData  = in_px[i];
      end
      acc = bus.iValid && bus.oReady;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        if (i == 0) acc_cyc = ncyc;
        i++;
        run++;
        // Pad settings changed mid-frame must not affect this frame
        if (twiddle && i == 3) begin
          bus.padMode  = mode ^ 2'b01;
          bus.padConst = ~pc;
        end
      end
    end
    bus.iValid = 1'b0;
    chk("send_all", 32'(i), 32'(npix));
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int k = 0; k < 1000 && done_seen < target; k++) @(posedge clk);
    #1;
    chk({tag, "_done_seen"}, 32'(done_seen >= target), 32'd1);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, 32'(got_px.size()), 32'(exp_px.size()));
    for (int k = 0; k < exp_px.size() && k < got_px.size(); k++) begin
      chk($sformatf("%s_px%0d", tag, k), 32'(got_px[k]), 32'(exp_px[k]));
      chk($sformatf("%s_fl%0d", tag, k), 32'(got_fl[k]), 32'(exp_fl[k]));
    end
    chk({tag, "_flag_wo_valid"}, 32'(bad_done), 32'd0);
    got_px.delete(); got_fl.delete();
    exp_px.delete(); exp_fl.delete();
  endtask

  task automatic load_seq();
    for (int k = 0; k < NPIX; k++) in_px[k] = 24'(k + 1);
  endtask

  task automatic load_rand();
    for (int k = 0; k < NPIX; k++) in_px[k] = 24'($urandom);
  endtask

  task automatic run_frame(input string tag, input logic [1:0] mode, input logic [23:0] pc,
                           input int gap_mode, input bit twiddle, input bit lat);
    int base;
    base = done_seen;
    model_frame(mode, pc);
    send_frame(mode, pc, gap_mode, twiddle, NPIX);
    wait_done(base + 1, tag);
    check_frames(tag);
    if (lat) chk({tag, "_first_latency"}, 32'(first_cyc - acc_cyc), 32'd2);
  endtask

  initial begin
    int base;
    logic ovf_exp;
    logic rdy;
    bus.iValid = 1'b0; bus.iData = '0; bus.padMode = 2'd0; bus.padConst = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {26'd0, bus.oValid, bus.oFirst, bus.oLast, bus.oDone, bus.oOverflow, bus.oReady},
        32'h1);
    chk("reset_data", 32'(bus.oData), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    load_seq();
    run_frame("zero", 2'd0, 24'h0, 0, 1'b1, 1'b1);
    run_frame("const", 2'd1, 24'hAABBCC, 0, 1'b1, 1'b1);
    run_frame("repl", 2'd2, 24'h0, 0, 1'b1, 1'b1);
    run_frame("gap2", 2'd0, 24'h0, 1, 1'b0, 1'b0);
    run_frame("repl_gap2", 2'd2, 24'h123456, 1, 1'b0, 1'b0);
    run_frame("mode3", 2'd3, 24'h654321, 0, 1'b0, 1'b0);

    // Two frames back to back: second frame's pixels arrive during BOTTOM
    base = done_seen;
    load_rand();
    model_frame(2'd2, 24'h0);
    send_frame(2'd2, 24'h0, 0, 1'b0, NPIX);
    load_rand();
    model_frame(2'd2, 24'h0);
    send_frame(2'd2, 24'h0, 0, 1'b0, NPIX);
    wait_done(base + 2, "b2b");
    check_frames("b2b");

    for (int f = 0; f < 4; f++) begin
      load_rand();
      run_frame($sformatf("rand%0d", f), 2'($urandom_range(0, 3)), 24'($urandom), 2, 1'b1, 1'b0);
    end
    chk("no_overflow", 32'(bus.oOverflow), 32'd0);

    // Reset in the middle of data row 2, then a fresh frame
    load_seq();
    send_frame(2'd0, 24'h0, 0, 1'b0, 7);
    for (int k = 0; k < 500 && got_px.size() < 14; k++) @(posedge clk);
    chk("mid_reached", 32'(got_px.size() >= 14), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_flags", {27'd0, bus.oValid, bus.oFirst, bus.oLast, bus.oDone, bus.oReady}, 32'h1);
    reset = 1'b0;
    got_px.delete(); got_fl.delete();
    @(posedge clk); #1;
    run_frame("after_reset", 2'd0, 24'h0, 0, 1'b0, 1'b1);

    // Source ignoring back-pressure: overflow is sticky until reset
    ovf_exp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.iValid = 1'b1;
      bus.iData  = 24'(k);
      rdy = bus.oReady;
      @(posedge clk); #1;
      if (!rdy) ovf_exp = 1'b1;
      chk($sformatf("ovf_step%0d", k), 32'(bus.oOverflow), 32'(ovf_exp));
    end
    bus.iValid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("ovf_sticky", 32'(bus.oOverflow), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("ovf_cleared", 32'(bus.oOverflow), 32'd0);
    chk("ovf_ready", 32'(bus.oReady), 32'd1);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
